// File: rtl/otter_iobus_pkg.sv
// Shared constants, register selector and address decode for the OTTER I/O-bus FIFO/timer block.
package otter_iobus_pkg;

    localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFF_POP    = 32'h0000_0004;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0008;
    localparam logic [31:0] OFF_TIMER  = 32'h0000_000C;
    localparam logic [31:0] OFF_CTRL   = 32'h0000_0010;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_TPEND     = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_FIFO_IE     = 0;
    localparam int CTRL_TIMER_IE    = 1;
    localparam int CTRL_AUTO_RELOAD = 2;

    typedef enum logic [2:0] {
        SEL_DATA,
        SEL_POP,
        SEL_STATUS,
        SEL_TIMER,
        SEL_CTRL,
        SEL_NONE
    } reg_sel_t;

    // Exact-match decode: misaligned or out-of-block addresses select nothing.
    function automatic reg_sel_t decode_addr(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        case (off)
            OFF_DATA:   return SEL_DATA;
            OFF_POP:    return SEL_POP;
            OFF_STATUS: return SEL_STATUS;
            OFF_TIMER:  return SEL_TIMER;
            OFF_CTRL:   return SEL_CTRL;
            default:    return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/iobus_fifo.sv
// Circular word FIFO with occupancy count; head reads as zero while empty.
module iobus_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [31:0]                din,
    output logic [31:0]                head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? 32'h0 : mem[rd_ptr];

    // Storage is never reset; an empty FIFO hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/otter_iobus_fifo_timer.sv
// Memory-mapped FIFO plus optional countdown timer on the OTTER I/O bus.
// Timer, TIMER register, tpend and CTRL[2:1] exist only with OTTER_IOBUS_TIMER_EN defined.
module otter_iobus_fifo_timer
    import otter_iobus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int          DEPTH     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);
    reg_sel_t                sel;
    logic                    wr_data;
    logic                    wr_pop;
    logic                    wr_status;
    logic                    wr_timer;
    logic                    wr_ctrl;
    logic [31:0]             head;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    empty;
    logic                    ovf;
    logic                    tpend;
    logic [31:0]             counter;
    logic [2:0]              ctrl;
    logic [2:0]              ctrl_mask;
    logic [31:0]             status;
    logic [31:0]             rdata;

    assign sel       = decode_addr(IOBUS_ADDR, BASE_ADDR);
    assign wr_data   = IOBUS_WR && (sel == SEL_DATA);
    assign wr_pop    = IOBUS_WR && (sel == SEL_POP);
    assign wr_status = IOBUS_WR && (sel == SEL_STATUS);
    assign wr_timer  = IOBUS_WR && (sel == SEL_TIMER);
    assign wr_ctrl   = IOBUS_WR && (sel == SEL_CTRL);

    iobus_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (wr_data),
        .pop   (wr_pop),
        .din   (IOBUS_OUT),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf <= 1'b0;
        end else if (wr_data && full) begin
            ovf <= 1'b1;
        end else if (wr_status && IOBUS_OUT[ST_OVF]) begin
            ovf <= 1'b0;
        end
    end

`ifdef OTTER_IOBUS_TIMER_EN
    logic [31:0] reload;

    assign ctrl_mask = 3'b111;

    // A TIMER write takes priority over an expiry in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            counter <= '0;
            reload  <= '0;
            tpend   <= 1'b0;
        end else if (wr_timer) begin
            counter <= IOBUS_OUT;
            reload  <= IOBUS_OUT;
            tpend   <= 1'b0;
        end else begin
            if (counter == 32'd1) begin
                tpend   <= 1'b1;
                counter <= ctrl[CTRL_AUTO_RELOAD] ? reload : 32'h0;
            end else if (counter != 32'h0) begin
                counter <= counter - 32'd1;
            end
            if (wr_status && IOBUS_OUT[ST_TPEND]) begin
                tpend <= 1'b0;
            end
        end
    end
`else
    assign ctrl_mask = 3'b001;
    assign counter   = 32'h0;
    assign tpend     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl <= IOBUS_OUT[2:0] & ctrl_mask;
        end
    end

    always_comb begin
        status                  = 32'h0;
        status[ST_COUNT_LSB+:8] = 8'(count);
        status[ST_TPEND]        = tpend;
        status[ST_OVF]          = ovf;
        status[ST_FULL]         = full;
        status[ST_EMPTY]        = empty;
    end

    always_comb begin
        rdata = 32'h0;
        case (sel)
            SEL_DATA:   rdata = head;
            SEL_STATUS: rdata = status;
            SEL_TIMER:  rdata = counter;
            SEL_CTRL:   rdata = {29'h0, ctrl};
            default:    rdata = 32'h0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            IOBUS_IN <= 32'h0;
            INTR     <= 1'b0;
        end else begin
            IOBUS_IN <= rdata;
            INTR     <= (ctrl[CTRL_FIFO_IE] && !empty) || (ctrl[CTRL_TIMER_IE] && tpend);
        end
    end

endmodule

// File: tb/tb_otter_iobus_fifo_timer.sv
// Directed self-checking bench for otter_iobus_fifo_timer (DEPTH=8, default base).
module tb_otter_iobus_fifo_timer;
    localparam logic [31:0] BASE = 32'h1100_0100;

    logic        CLK;
    logic        RST;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        INTR;

    int total  = 0;
    int passed = 0;

    otter_iobus_fifo_timer #(.BASE_ADDR(BASE), .DEPTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .INTR       (INTR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        @(posedge CLK);
        #1;
        IOBUS_WR = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge CLK);
        IOBUS_ADDR = addr;
        IOBUS_WR   = 1'b0;
        @(posedge CLK);
        #1;
        check(tag, IOBUS_IN, exp);
    endtask

    task automatic idle();
        @(negedge CLK);
        IOBUS_ADDR = 32'h0;
        IOBUS_WR   = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST        = 1'b1;
        IOBUS_ADDR = 32'h0;
        IOBUS_OUT  = 32'h0;
        IOBUS_WR   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_iobus_in", IOBUS_IN, 32'h0);
        check("rst_intr", {31'h0, INTR}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        rd("status_after_reset", BASE + 32'h08, 32'h0000_0001);
        check("intr_after_reset", {31'h0, INTR}, 32'h0);

        wr(BASE + 32'h00, 32'hA5A5_0001);
        wr(BASE + 32'h00, 32'h0000_0002);
        rd("data_head_first", BASE + 32'h00, 32'hA5A5_0001);
        rd("data_peek_no_pop", BASE + 32'h00, 32'hA5A5_0001);
        rd("status_count2", BASE + 32'h08, 32'h0000_0200);
        wr(BASE + 32'h04, 32'hDEAD_BEEF);
        rd("data_after_pop", BASE + 32'h00, 32'h0000_0002);
        rd("status_count1", BASE + 32'h08, 32'h0000_0100);
        wr(BASE + 32'h04, 32'h0);
        wr(BASE + 32'h04, 32'h0);
        rd("status_pop_empty_noop", BASE + 32'h08, 32'h0000_0001);
        rd("data_empty_zero", BASE + 32'h00, 32'h0);

        wr(BASE + 32'h20, 32'h1234_5678);
        wr(BASE - 32'h04, 32'h1234_5678);
        wr(BASE + 32'h01, 32'h1234_5678);
        rd("status_outside_write", BASE + 32'h08, 32'h0000_0001);
        rd("unmapped_read", BASE + 32'h14, 32'h0);
        rd("pop_read_zero", BASE + 32'h04, 32'h0);

        for (int i = 0; i < 9; i++) begin
            wr(BASE + 32'h00, 32'h100 + i);
        end
        rd("status_full_ovf", BASE + 32'h08, 32'h0000_0806);
        wr(BASE + 32'h08, 32'h0000_0004);
        rd("status_ovf_cleared", BASE + 32'h08, 32'h0000_0802);
        for (int i = 0; i < 8; i++) begin
            rd($sformatf("drain_%0d", i), BASE + 32'h00, 32'h100 + i);
            wr(BASE + 32'h04, 32'h0);
        end
        rd("status_drained", BASE + 32'h08, 32'h0000_0001);
        rd("ninth_absent", BASE + 32'h00, 32'h0);

        wr(BASE + 32'h10, 32'h1);
        rd("ctrl_readback1", BASE + 32'h10, 32'h1);
        check("intr_empty_low", {31'h0, INTR}, 32'h0);
        wr(BASE + 32'h00, 32'hCAFE_0000);
        check("intr_push_latency", {31'h0, INTR}, 32'h0);
        idle();
        check("intr_fifo_high", {31'h0, INTR}, 32'h1);
        wr(BASE + 32'h04, 32'h0);
        check("intr_pop_latency", {31'h0, INTR}, 32'h1);
        idle();
        check("intr_fifo_low", {31'h0, INTR}, 32'h0);

`ifdef OTTER_IOBUS_TIMER_EN
        wr(BASE + 32'h10, 32'h7);
        rd("ctrl_readback7", BASE + 32'h10, 32'h7);
        wr(BASE + 32'h10, 32'h0);
        wr(BASE + 32'h0C, 32'h5);
        rd("timer_read_loaded", BASE + 32'h0C, 32'h5);
        wr(BASE + 32'h0C, 32'h0);
        rd("timer_stopped", BASE + 32'h0C, 32'h0);

        wr(BASE + 32'h10, 32'h2);
        wr(BASE + 32'h0C, 32'h3);
        rd("tpend_c1", BASE + 32'h08, 32'h0000_0001);
        rd("tpend_c2", BASE + 32'h08, 32'h0000_0001);
        rd("tpend_c3", BASE + 32'h08, 32'h0000_0001);
        check("intr_before_tpend", {31'h0, INTR}, 32'h0);
        rd("tpend_set", BASE + 32'h08, 32'h0000_0009);
        check("intr_timer_high", {31'h0, INTR}, 32'h1);
        rd("timer_stays_zero", BASE + 32'h0C, 32'h0);
        wr(BASE + 32'h08, 32'h0000_0008);
        check("intr_clear_latency", {31'h0, INTR}, 32'h1);
        idle();
        check("intr_timer_low", {31'h0, INTR}, 32'h0);
        rd("tpend_cleared", BASE + 32'h08, 32'h0000_0001);

        wr(BASE + 32'h10, 32'h6);
        wr(BASE + 32'h0C, 32'h2);
        idle();
        idle();
        rd("reload_counter", BASE + 32'h0C, 32'h2);
        rd("reload_tpend", BASE + 32'h08, 32'h0000_0009);
        idle();
        wr(BASE + 32'h0C, 32'h10);
        rd("expiry_write_value", BASE + 32'h0C, 32'h10);
        rd("expiry_write_tpend", BASE + 32'h08, 32'h0000_0001);
        wr(BASE + 32'h0C, 32'h0);
        wr(BASE + 32'h10, 32'h0);
`else
        wr(BASE + 32'h0C, 32'h5);
        rd("timer_disabled_read", BASE + 32'h0C, 32'h0);
        wr(BASE + 32'h10, 32'h7);
        rd("ctrl_disabled_mask", BASE + 32'h10, 32'h1);
        wr(BASE + 32'h08, 32'h0000_000C);
        rd("status_disabled", BASE + 32'h08, 32'h0000_0001);
        wr(BASE + 32'h10, 32'h0);
`endif

        wr(BASE + 32'h10, 32'h1);
        wr(BASE + 32'h00, 32'h0BAD_0BAD);
        @(negedge CLK);
        RST        = 1'b1;
        IOBUS_ADDR = BASE + 32'h00;
        IOBUS_OUT  = 32'h0000_0077;
        IOBUS_WR   = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_mid_iobus_in", IOBUS_IN, 32'h0);
        check("rst_mid_intr", {31'h0, INTR}, 32'h0);
        @(negedge CLK);
        RST      = 1'b0;
        IOBUS_WR = 1'b0;
        rd("rst_status", BASE + 32'h08, 32'h0000_0001);
        rd("rst_ctrl", BASE + 32'h10, 32'h0);
        rd("rst_data_empty", BASE + 32'h00, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/otter_iobus_fifo_timer.md
OTTER_IOBUS_FIFO_TIMER -- requirements
Module: otter_iobus_fifo_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1100_0100, byte address of register block (word aligned).
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port IOBUS_ADDR  input  32  byte address driven by MCU.
REQ-006 SHALL have port IOBUS_OUT  input  32  write data from MCU.
REQ-007 SHALL have port IOBUS_WR  input  1  write strobe; one write per asserted cycle.
REQ-008 SHALL have port IOBUS_IN  output  32  read data to MCU.
REQ-009 SHALL have port INTR  output  1  level interrupt request to MCU.

Function
REQ-010 SHALL decode word offsets from BASE_ADDR: 0x00 DATA, 0x04 POP, 0x08 STATUS, 0x0C TIMER, 0x10 CTRL; other addresses unmapped.
REQ-011 SHALL register IOBUS_IN: value reflects IOBUS_ADDR sampled at previous edge (1-cycle read latency, matching synchronous memory).
REQ-012 SHALL have side-effect-free reads; unmapped or out-of-block reads return 32'h0.
REQ-013 DATA write SHALL push IOBUS_OUT when not full; when full, data is dropped, count unchanged, STATUS.ovf set (sticky).
REQ-014 DATA read SHALL return head entry without popping; returns 0 when empty.
REQ-015 POP write (any data) SHALL remove head when not empty; when empty, no-op.
REQ-016 STATUS read SHALL return {count[7:0] at bits 15:8, tpend bit 3, ovf bit 2, full bit 1, empty bit 0}, other bits 0.
REQ-017 STATUS write SHALL clear ovf when bit 2 = 1 and tpend when bit 3 = 1; other bits ignored.
REQ-018 FIFO pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-019 TIMER write SHALL load counter and reload register with IOBUS_OUT and clear tpend; write of 0 stops timer.
REQ-020 Nonzero counter SHALL decrement by 1 per cycle; on 1->0 transition tpend set; if CTRL[2] then counter reloads from reload register in same cycle, otherwise stays 0.
REQ-021 TIMER write coinciding with expiry SHALL win: new value loaded, tpend cleared.
REQ-022 TIMER read SHALL return current counter value.
REQ-023 CTRL SHALL be 3-bit R/W: bit0 FIFO-nonempty irq enable, bit1 timer irq enable, bit2 auto-reload; upper bits read 0.
REQ-024 INTR SHALL be registered, = (CTRL[0] & !empty) | (CTRL[1] & tpend), one cycle after state change.
REQ-025 Writes outside block SHALL not change any state.

Reset
REQ-026 RST SHALL clear pointers, count, ovf, tpend, counter, reload, CTRL; IOBUS_IN = 0, INTR = 0 on next edge.
REQ-027 RST SHALL override a simultaneous IOBUS_WR; FIFO contents need not be cleared (unreadable when empty).

Configuration
REQ-028 Macro OTTER_IOBUS_TIMER_EN defined: timer, TIMER register, tpend and CTRL[2:1] SHALL exist as above.
REQ-029 Macro undefined: no timer logic; TIMER reads 0, writes ignored, tpend/CTRL[2:1] read 0, INTR = CTRL[0] & !empty.

Structure
REQ-030 Package otter_iobus_pkg SHALL hold register offset constants, STATUS/CTRL bit-position constants, and a reg_sel_t enum (DATA, POP, STATUS, TIMER, CTRL, NONE).
REQ-031 FIFO storage/pointers SHALL be a sub-module iobus_fifo (push, pop, head, count, full, empty); decode, timer, read mux in top.

Verification
REQ-032 Reset then read STATUS -> IOBUS_IN = 32'h0000_0001 one cycle later; INTR = 0.
REQ-033 Push 0xA5A5_0001, 0x0000_0002; read DATA -> 0xA5A5_0001; POP; read DATA -> 0x0000_0002; STATUS count = 1.
REQ-034 Push 9 words (DEPTH=8) -> STATUS = 0x0000_0806 (count 8, ovf, full); write STATUS 0x4 -> ovf cleared, 9th word absent.
REQ-035 CTRL=0x2, TIMER=3 -> tpend set 3 cycles after write, INTR high next cycle; write STATUS 0x8 -> INTR low one cycle later.
REQ-036 CTRL=0x6, TIMER=2 -> tpend set and counter reads 2 after expiry; TIMER write on expiry cycle -> new value loaded, tpend 0.
REQ-037 Build without OTTER_IOBUS_TIMER_EN: TIMER write 5 then read -> 0; CTRL write 0x7 reads back 0x1.
